pipe_dmem_arbiter: RTL
======================

Name: pipe_dmem_arbiter

Overview:
Shares the single data-RAM port of the MEM stage between the pipeline (CPU port) and an external DMA/debug loader that fills or dumps data memory in bursts.
- CPU has priority by default.
- A starvation counter and a per-grant burst cap guarantee DMA progress.
- While DMA owns the RAM, the arbiter raises cpu_stall, which freezes the pipeline in the same way wpcir does.
- Sits between pipemem and the data RAM.

Parameters:
ADDR_W, 5, RAM word-address width
STARVE_MAX, 4, cycles a pending DMA request may be refused before it is forced in
BURST_MAX, 4, max DMA beats per grant while cpu_req is pending

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
cpu_req  in  1  MEM stage accesses RAM this cycle
cpu_we  in  1  MEM stage write
cpu_addr  in  32  byte address; bits [ADDR_W+1:2] used
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data (ram_rdata passthrough)
cpu_stall  out  1  pipeline must hold
dma_req  in  1  burst request; held high until dma_done
dma_we  in  1  burst direction (1 = write)
dma_addr  in  ADDR_W  burst start word address
dma_len  in  4  beats minus 1 (1..16 beats)
dma_wdata  in  32  write data for current beat
dma_beat  out  1  beat consumed this cycle
dma_rdata  out  32  registered read data
dma_rvalid  out  1  dma_rdata valid
dma_done  out  1  one-cycle pulse, burst complete
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid in the same cycle (RAM clocked on ~clock)

Behaviour:
- Reset (resetn=0 at a rising edge): state S_CPU; wait_cnt, beat_cnt and slot_cnt = 0; dma_rvalid, dma_done and dma_rdata = 0. Combinational outputs then read cpu_stall=0, dma_beat=0, ram_we=cpu_req&cpu_we. A reset mid-burst aborts the burst with no dma_done.
- S_CPU:
  - RAM port driven by CPU: ram_we=cpu_req&cpu_we, ram_addr=cpu_addr[ADDR_W+1:2], ram_wdata=cpu_wdata. cpu_stall=0.
  - wait_cnt increments, saturating at STARVE_MAX, each cycle dma_req=1 without a grant.
  - Grant when dma_req && (!cpu_req || wait_cnt>=STARVE_MAX). The grant is registered: the CPU is still served in the grant cycle and DMA owns the RAM from the next cycle.
  - On a new burst grant: latch dma_addr→base, dma_len→len and dma_we→we; clear beat_cnt; clear wait_cnt.
  - On a resumed burst grant: keep base, len, we and beat_cnt.
  - On any grant: slot_cnt=0.
- S_DMA:
  - ram_addr=(base+beat_cnt) mod 2^ADDR_W; ram_we=we; ram_wdata=dma_wdata. dma_beat=1 every cycle. cpu_stall=cpu_req.
  - Read beats: dma_rdata<=ram_rdata and dma_rvalid=1 in the next cycle.
  - Each cycle: beat_cnt++, slot_cnt++.
  - Last beat (beat_cnt==len): go to S_CPU; dma_done=1 in the next cycle, aligned with the last dma_rvalid.
  - Preempt (slot_cnt==BURST_MAX-1 && cpu_req && not last beat): go to S_CPU, mark burst resumed, preset wait_cnt=STARVE_MAX. Net effect: exactly one CPU cycle, then DMA resumes.
- dma_req falling mid-burst is ignored; the burst completes.
- A new request is accepted only after dma_done, once dma_req is high again.
- cpu_rdata=ram_rdata always; its value is meaningful only when cpu_req && !cpu_stall.

Decomposition:
- Package pipe_arb_pkg:
  - state enum {S_CPU, S_DMA}
  - default parameter constants
  - DATA_W=32
- One natural sub-module: pipe_arb_burst_ctr. It holds base/len/beat_cnt/slot_cnt, produces the address and the last/preempt flags, and is reused by a future IF-side loader.

Test Plan:
1. resetn=0 for 2 cycles with dma_req=1, cpu_req=1 → cpu_stall=0, dma_beat=0, dma_rvalid=0, dma_done=0. Then release with dma_req=0.
2. CPU-only sequence:
   - sw 0x1234 at 0x8 → ram_we=1, ram_addr=2, ram_wdata=0x1234 in the same cycle.
   - lw at 0x8 → cpu_rdata=0x1234.
   - cpu_stall never asserted.
3. CPU idle; DMA write base=3, len=3, data A,B,C,D → dma_beat on cycles 2–5, ram_addr 3,4,5,6, dma_done on cycle 6.
4. cpu_req held continuously; dma_req from cycle 0; STARVE_MAX=4 → grant at cycle 4, S_DMA from cycle 5 with cpu_stall=1, CPU served every cycle 0–4.
5. cpu_req continuous; DMA read len=9 (10 beats); BURST_MAX=4 → 4 beats, 1 CPU cycle, 4 beats, 1 CPU cycle, 2 beats; 10 dma_rvalid pulses; one dma_done.
6. Wrap and reset:
   - ADDR_W=5, base=30, len=3 → ram_addr 30,31,0,1.
   - Repeat with resetn=0 after beat 2 → S_CPU and no dma_done.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types and defaults for the MEM-stage data-RAM arbiter and its burst counter.
package pipe_arb_pkg;

  localparam int DATA_W         = 32;
  localparam int LEN_W          = 4;
  localparam int ADDR_W_DEF     = 5;
  localparam int STARVE_MAX_DEF = 4;
  localparam int BURST_MAX_DEF  = 4;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pipe_arb_burst_ctr.sv
// Burst bookkeeping: base/length/beat/slot counters, beat address and last/preempt flags.
// Kept free of arbiter policy so an IF-side loader can reuse it.
module pipe_arb_burst_ctr
  import pipe_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              hold_req_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              preempt_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic              slot_full;

  always_comb begin
    // NOTE: every next-state variable gets a default first, otherwise a latch is inferred.
    base_d     = base_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (load_i) begin
      base_d     = base_i;
      len_d      = len_i;
      beat_cnt_d = '0;
    end
    if (start_i) begin
      slot_cnt_d = '0;
    end
    if (step_i) begin
      beat_cnt_d = beat_cnt_q + LEN_W'(1);
      slot_cnt_d = slot_cnt_q + LEN_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      base_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      slot_cnt_q <= '0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  // Address wraps naturally at 2^ADDR_W.
  assign addr_o    = base_q + ADDR_W'(beat_cnt_q);
  assign last_o    = (beat_cnt_q == len_q);
  assign slot_full = (slot_cnt_q >= LEN_W'(BURST_MAX - 1));
  assign preempt_o = slot_full && hold_req_i && !last_o;

endmodule

// File: rtl/pipe_dmem_arbiter.sv
// Shares the MEM-stage data-RAM port between the pipeline (default priority) and a DMA/debug
// burst loader; starvation counter and per-grant burst cap guarantee both sides progress.
module pipe_dmem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [3:0]        dma_len,
  input  logic [31:0]       dma_wdata,
  output logic              dma_beat,
  output logic [31:0]       dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int                WAIT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              resumed_q, resumed_d;
  logic              we_q, we_d;
  logic              dma_rvalid_q, dma_done_q;
  logic [DATA_W-1:0] dma_rdata_q;

  logic              in_dma, pending, grant, last, preempt;
  logic [ADDR_W-1:0] burst_addr;
  logic              unused_addr_bits;

  assign in_dma  = (state_q == S_DMA);
  // A preempted burst resumes regardless of dma_req; a fresh one waits out the done pulse.
  assign pending = resumed_q || (dma_req && !dma_done_q);
  assign grant   = !in_dma && pending && (!cpu_req || (wait_cnt_q >= WAIT_SAT));

  pipe_arb_burst_ctr #(
    .ADDR_W   (ADDR_W),
    .BURST_MAX(BURST_MAX)
  ) u_burst_ctr (
    .clock     (clock),
    .resetn    (resetn),
    .load_i    (grant && !resumed_q),
    .start_i   (grant),
    .step_i    (in_dma),
    .hold_req_i(cpu_req),
    .base_i    (dma_addr),
    .len_i     (dma_len),
    .addr_o    (burst_addr),
    .last_o    (last),
    .preempt_o (preempt)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    resumed_d  = resumed_q;
    we_d       = we_q;
    if (!in_dma) begin
      if (grant) begin
        state_d    = S_DMA;
        wait_cnt_d = '0;
        resumed_d  = 1'b0;
        if (!resumed_q) we_d = dma_we;
      end else if (pending && (wait_cnt_q < WAIT_SAT)) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end else if (last) begin
      state_d = S_CPU;
    end else if (preempt) begin
      // Saturated wait count re-grants after exactly one CPU cycle.
      state_d    = S_CPU;
      resumed_d  = 1'b1;
      wait_cnt_d = WAIT_SAT;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_CPU;
      wait_cnt_q   <= '0;
      resumed_q    <= 1'b0;
      we_q         <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_done_q   <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      resumed_q    <= resumed_d;
      we_q         <= we_d;
      dma_rvalid_q <= in_dma && !we_q;
      dma_done_q   <= in_dma && last;
      if (in_dma && !we_q) dma_rdata_q <= ram_rdata;
    end
  end

  assign ram_we     = in_dma ? we_q       : (cpu_req & cpu_we);
  assign ram_addr   = in_dma ? burst_addr : cpu_addr[ADDR_W+1:2];
  assign ram_wdata  = in_dma ? dma_wdata  : cpu_wdata;
  assign cpu_rdata  = ram_rdata;
  assign cpu_stall  = in_dma & cpu_req;
  assign dma_beat   = in_dma;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_done   = dma_done_q;

  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

endmodule
